// File: rtl/zx_kbd_pkg.sv
// Shared definitions for the PS/2 to ZX Spectrum keyboard responder.
// Holds the PS/2 prefix bytes, matrix index types, the receiver state
// encoding and the {ext, code} -> (row, col) keymap.
package zx_kbd_pkg;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_REL   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;

    localparam int unsigned ZX_ROWS = 8;
    localparam int unsigned ZX_COLS = 5;

    typedef logic [2:0] row_t;
    typedef logic [2:0] col_t;

    typedef struct packed {
        logic valid;
        row_t row;
        col_t col;
    } key_loc_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    function automatic key_loc_t key_at(input int unsigned r, input int unsigned c);
        key_loc_t k;
        k.valid = 1'b1;
        k.row   = row_t'(r);
        k.col   = col_t'(c);
        return k;
    endfunction

    // Set-2 scan code to Spectrum matrix position. Only right ctrl and
    // keypad enter are recognised behind the E0 prefix.
    function automatic key_loc_t keymap(input logic ext, input logic [7:0] code);
        key_loc_t k;
        k = '0;
        if (ext) begin
            case (code)
                8'h14:   k = key_at(7, 1);
                8'h5A:   k = key_at(6, 0);
                default: k = '0;
            endcase
        end else begin
            case (code)
                8'h12, 8'h59: k = key_at(0, 0);
                8'h1A: k = key_at(0, 1);
                8'h22: k = key_at(0, 2);
                8'h21: k = key_at(0, 3);
                8'h2A: k = key_at(0, 4);
                8'h1C: k = key_at(1, 0);
                8'h1B: k = key_at(1, 1);
                8'h23: k = key_at(1, 2);
                8'h2B: k = key_at(1, 3);
                8'h34: k = key_at(1, 4);
                8'h15: k = key_at(2, 0);
                8'h1D: k = key_at(2, 1);
                8'h24: k = key_at(2, 2);
                8'h2D: k = key_at(2, 3);
                8'h2C: k = key_at(2, 4);
                8'h16: k = key_at(3, 0);
                8'h1E: k = key_at(3, 1);
                8'h26: k = key_at(3, 2);
                8'h25: k = key_at(3, 3);
                8'h2E: k = key_at(3, 4);
                8'h45: k = key_at(4, 0);
                8'h46: k = key_at(4, 1);
                8'h3E: k = key_at(4, 2);
                8'h3D: k = key_at(4, 3);
                8'h36: k = key_at(4, 4);
                8'h4D: k = key_at(5, 0);
                8'h44: k = key_at(5, 1);
                8'h43: k = key_at(5, 2);
                8'h3C: k = key_at(5, 3);
                8'h35: k = key_at(5, 4);
                8'h5A: k = key_at(6, 0);
                8'h4B: k = key_at(6, 1);
                8'h42: k = key_at(6, 2);
                8'h3B: k = key_at(6, 3);
                8'h33: k = key_at(6, 4);
                8'h29: k = key_at(7, 0);
                8'h14: k = key_at(7, 1);
                8'h3A: k = key_at(7, 2);
                8'h31: k = key_at(7, 3);
                8'h32: k = key_at(7, 4);
                default: k = '0;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_zx_keyboard_if.sv
// ULA keyboard port: row selects (A15..A8, active-low) driven by the ULA,
// column bits (active-low) returned by the keyboard.
//   master : ULA side      (drives rows, reads columns)
//   slave  : keyboard side (reads rows, drives columns)
interface ps2_zx_keyboard_if;
    logic [7:0] rows;
    logic [4:0] columns;

    modport master (output rows, input columns);
    modport slave  (input rows, output columns);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: input synchronisers, ps2clk glitch filter, frame FSM
// with parity/stop checking and an inactivity timeout.
//   clk, reset_n      : system clock, async active-low reset
//   ps2clk, ps2data   : raw PS/2 lines (asynchronous)
//   byte_o            : last byte received without error
//   valid_o           : one-cycle pulse when byte_o is loaded
module ps2_rx
    import zx_kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 14000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] byte_o,
    output logic       valid_o
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    rx_state_t     state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          strobe, timeout, accept;

    // Filtered clock flips only after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_sync_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
        strobe = filt_q & ~filt_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        timeout = (state_q != RX_IDLE) && !strobe && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
        state_d = state_q;
        if (timeout) begin
            state_d = RX_IDLE;
        end else if (strobe) begin
            case (state_q)
                RX_IDLE:   if (!dat_sync_q) state_d = RX_DATA;
                RX_DATA:   if (bitcnt_q == 3'd7) state_d = RX_PARITY;
                RX_PARITY: state_d = RX_STOP;
                default:   state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        to_cnt_d = (state_q == RX_IDLE || strobe || timeout) ? '0 : to_cnt_q + TW'(1);
        accept   = 1'b0;
        if (strobe && !timeout) begin
            case (state_q)
                RX_IDLE:   bitcnt_d = '0;
                RX_DATA: begin
                    shift_d  = {dat_sync_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                end
                RX_PARITY: par_d = dat_sync_q;
                default:   accept = dat_sync_q && (^{shift_q, par_q});
            endcase
        end
        valid_d = accept;
        byte_d  = accept ? shift_q : byte_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            clk_meta_q <= ps2clk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2data;
            dat_sync_q <= dat_meta_q;
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
        end
    end

    assign byte_o  = byte_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ps2_zx_keyboard.sv
// PS/2 keyboard standing in for the ZX Spectrum membrane matrix.
// Decodes set-2 scan codes into an 8x5 key matrix and answers ULA row
// selects combinationally with the OR of the selected rows' keys.
//   clk, reset_n            : system clock (clk14), async active-low reset
//   ps2clk, ps2data         : PS/2 lines from the keyboard
//   kbd (slave)             : rows in / columns out, both active-low
//   scancode/scancode_valid : last good byte and its one-cycle update pulse
module ps2_zx_keyboard
    import zx_kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 14000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ps2clk,
    input  logic                  ps2data,
    ps2_zx_keyboard_if.slave      kbd,
    output logic [7:0]            scancode,
    output logic                  scancode_valid
);

    logic [7:0] rx_byte;
    logic       rx_valid;

    ps2_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk    (clk),
        .reset_n(reset_n),
        .ps2clk (ps2clk),
        .ps2data(ps2data),
        .byte_o (rx_byte),
        .valid_o(rx_valid)
    );

    assign scancode       = rx_byte;
    assign scancode_valid = rx_valid;

    logic [ZX_ROWS-1:0][ZX_COLS-1:0] matrix_q, matrix_d;
    logic                            ext_q, ext_d, rel_q, rel_d;
    logic [2:0]                      skip_q, skip_d;
    key_loc_t                        km;
    logic [ZX_COLS-1:0]              hit;

    always_comb begin
        matrix_d = matrix_q;
        ext_d    = ext_q;
        rel_d    = rel_q;
        skip_d   = skip_q;
        km       = keymap(ext_q, rx_byte);
        if (rx_valid) begin
            if (skip_q != '0) begin
                skip_d = skip_q - 3'd1;
            end else if (rx_byte == SC_PAUSE) begin
                // Pause sends E1 plus seven more bytes; swallow them all.
                skip_d = 3'd7;
                ext_d  = 1'b0;
                rel_d  = 1'b0;
            end else if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_REL) begin
                rel_d = 1'b1;
            end else begin
                if (km.valid) matrix_d[km.row][km.col] = !rel_q;
                ext_d = 1'b0;
                rel_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            matrix_q <= '0;
            ext_q    <= 1'b0;
            rel_q    <= 1'b0;
            skip_q   <= '0;
        end else begin
            matrix_q <= matrix_d;
            ext_q    <= ext_d;
            rel_q    <= rel_d;
            skip_q   <= skip_d;
        end
    end

    always_comb begin
        hit = '0;
        for (int unsigned r = 0; r < ZX_ROWS; r++) begin
            if (!kbd.rows[r]) hit = hit | matrix_q[r];
        end
    end

    assign kbd.columns = ~hit;

endmodule

// File: tb/tb_ps2_zx_keyboard.sv
// Bench for ps2_zx_keyboard: directed frame table, hand-written corner
// sequences (timeout, glitches, pause, mid-frame reset) and random frames
// checked against a key-table model of the Spectrum matrix.
module tb_ps2_zx_keyboard;

    localparam int unsigned FILTER_LEN = 8;
    localparam int unsigned TIMEOUT    = 2000;
    localparam int unsigned HALF       = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2clk = 1'b1;
    logic       ps2data = 1'b1;
    logic [7:0] scancode;
    logic       scancode_valid;

    ps2_zx_keyboard_if kbd_if ();

    ps2_zx_keyboard #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ps2clk        (ps2clk),
        .ps2data       (ps2data),
        .kbd           (kbd_if),
        .scancode      (scancode),
        .scancode_valid(scancode_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;
    logic [7:0] last_sc = 8'h00;

    always @(negedge clk) begin
        if (scancode_valid) begin
            pulses  = pulses + 1;
            last_sc = scancode;
        end
    end

    // ---------------- reference model ----------------
    int  keytab [8][5] = '{
        '{'h12, 'h1A, 'h22, 'h21, 'h2A},
        '{'h1C, 'h1B, 'h23, 'h2B, 'h34},
        '{'h15, 'h1D, 'h24, 'h2D, 'h2C},
        '{'h16, 'h1E, 'h26, 'h25, 'h2E},
        '{'h45, 'h46, 'h3E, 'h3D, 'h36},
        '{'h4D, 'h44, 'h43, 'h3C, 'h35},
        '{'h5A, 'h4B, 'h42, 'h3B, 'h33},
        '{'h29, 'h14, 'h3A, 'h31, 'h32}
    };
    bit mdl [8][5];
    bit m_ext, m_rel;
    int m_skip;

    function automatic bit lookup(input bit ext, input logic [7:0] b, output int r, output int c);
        r = 0; c = 0;
        if (ext) begin
            if (b == 8'h14) begin r = 7; c = 1; return 1; end
            if (b == 8'h5A) begin r = 6; c = 0; return 1; end
            return 0;
        end
        if (b == 8'h59) begin r = 0; c = 0; return 1; end
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 5; j++)
                if (keytab[i][j] == int'(b)) begin r = i; c = j; return 1; end
        return 0;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 5; j++) mdl[i][j] = 0;
        m_ext = 0; m_rel = 0; m_skip = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int r, c;
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE1) begin m_skip = 7; m_ext = 0; m_rel = 0; end
        else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_rel = 1;
        else begin
            if (lookup(m_ext, b, r, c)) mdl[r][c] = !m_rel;
            m_ext = 0; m_rel = 0;
        end
    endfunction

    function automatic logic [4:0] model_cols(input logic [7:0] rws);
        logic [4:0] o = 5'b11111;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 5; j++)
                if (!rws[i] && mdl[i][j]) o[j] = 1'b0;
        return o;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rows_chk(input logic [7:0] r, input logic [4:0] exp, input string name);
        @(posedge clk);
        kbd_if.rows = r;
        @(negedge clk);
        chk(name, 32'(kbd_if.columns), 32'(exp));
    endtask

    task automatic send_bit(input logic b);
        ps2data = b;
        repeat (HALF) @(posedge clk);
        ps2clk = 1'b0;
        repeat (HALF) @(posedge clk);
        ps2clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par);
        logic [10:0] bits;
        logic        p;
        p = ~^b;
        if (bad_par) p = ~p;
        bits = {1'b1, p, b, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i]);
        repeat (30) @(posedge clk);
    endtask

    task automatic send_chk(input logic [7:0] b, input bit bad_par, input string name);
        int p0;
        p0 = pulses;
        send_frame(b, bad_par);
        chk({name, " pulses"}, 32'(pulses - p0), bad_par ? 32'd0 : 32'd1);
        if (!bad_par) begin
            chk({name, " scancode"}, 32'(last_sc), 32'(b));
            model_byte(b);
        end
    endtask

    typedef struct {
        logic [7:0] code;
        bit         bad;
        logic [7:0] rows1;
        logic [4:0] cols1;
        logic [7:0] rows2;
        logic [4:0] cols2;
        string      name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int p0;
        logic [7:0] b, rr;
        int sel, r, c;

        vecs.push_back('{8'h1C, 1'b0, 8'hFD, 5'b11110, 8'hFE, 5'b11111, "A press"});
        vecs.push_back('{8'hF0, 1'b0, 8'hFD, 5'b11110, 8'hFF, 5'b11111, "F0 prefix"});
        vecs.push_back('{8'h1C, 1'b0, 8'hFD, 5'b11111, 8'h00, 5'b11111, "A release"});
        vecs.push_back('{8'h15, 1'b1, 8'hFB, 5'b11111, 8'h00, 5'b11111, "Q bad parity"});
        vecs.push_back('{8'h15, 1'b0, 8'hFB, 5'b11110, 8'hFD, 5'b11111, "Q press"});
        vecs.push_back('{8'h1C, 1'b0, 8'hFD, 5'b11110, 8'hF9, 5'b11110, "A press again"});
        vecs.push_back('{8'hE0, 1'b0, 8'h7F, 5'b11111, 8'h00, 5'b11110, "E0 prefix"});
        vecs.push_back('{8'h14, 1'b0, 8'h7F, 5'b11101, 8'h00, 5'b11100, "right ctrl"});
        vecs.push_back('{8'hF0, 1'b0, 8'h7F, 5'b11101, 8'hFF, 5'b11111, "F0 before ctrl"});
        vecs.push_back('{8'h14, 1'b0, 8'h7F, 5'b11111, 8'h00, 5'b11110, "left ctrl release"});

        model_clear();
        kbd_if.rows = 8'h00;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("in-reset columns", 32'(kbd_if.columns), 32'h1F);
        reset_n = 1'b1;
        repeat (50) @(posedge clk);
        @(negedge clk);
        chk("reset columns", 32'(kbd_if.columns), 32'h1F);
        chk("reset scancode", 32'(scancode), 32'h00);
        chk("reset pulses", 32'(pulses), 32'd0);

        foreach (vecs[i]) begin
            send_chk(vecs[i].code, vecs[i].bad, vecs[i].name);
            rows_chk(vecs[i].rows1, vecs[i].cols1, {vecs[i].name, " rows1"});
            rows_chk(vecs[i].rows2, vecs[i].cols2, {vecs[i].name, " rows2"});
        end

        // Partial frame abandoned by the timeout, then a clean frame.
        p0 = pulses;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        repeat (TIMEOUT + 500) @(posedge clk);
        chk("partial frame pulses", 32'(pulses - p0), 32'd0);
        send_chk(8'h29, 1'b0, "space after timeout");
        rows_chk(8'h7F, 5'b11110, "space row");

        // Short ps2clk glitches with data low must not start a frame.
        p0 = pulses;
        ps2data = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ps2clk = 1'b0;
            repeat (FILTER_LEN - 2) @(posedge clk);
            ps2clk = 1'b1;
            repeat (10) @(posedge clk);
        end
        ps2data = 1'b1;
        repeat (20) @(posedge clk);
        chk("glitch pulses", 32'(pulses - p0), 32'd0);
        send_chk(8'h1A, 1'b0, "Z after glitches");
        rows_chk(8'hFE, 5'b11101, "Z row");

        // Pause sequence: the seven trailing bytes leave the matrix alone.
        send_chk(8'hE1, 1'b0, "pause E1");
        send_chk(8'h14, 1'b0, "pause b1");
        send_chk(8'h77, 1'b0, "pause b2");
        send_chk(8'hE1, 1'b0, "pause b3");
        send_chk(8'hF0, 1'b0, "pause b4");
        send_chk(8'h14, 1'b0, "pause b5");
        send_chk(8'hF0, 1'b0, "pause b6");
        send_chk(8'h77, 1'b0, "pause b7");
        rows_chk(8'h7F, 5'b11110, "after pause row7");
        send_chk(8'h1B, 1'b0, "S after pause");
        rows_chk(8'hFD, 5'b11100, "S row");

        // Random frames against the model.
        for (int n = 0; n < 50; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 50) begin
                r = $urandom_range(0, 7); c = $urandom_range(0, 4);
                b = 8'(keytab[r][c]);
            end else if (sel < 65) b = 8'hF0;
            else if (sel < 75) b = 8'hE0;
            else if (sel < 77) b = 8'hE1;
            else if (sel < 88) b = 8'($urandom);
            else b = 8'h59;
            send_chk(b, ($urandom_range(0, 7) == 0), $sformatf("rand%0d %0h", n, b));
            for (int k = 0; k < 2; k++) begin
                rr = 8'($urandom);
                if (k == 1) rr = ~(8'd1 << $urandom_range(0, 7));
                rows_chk(rr, model_cols(rr), $sformatf("rand%0d rows %0h", n, rr));
            end
        end

        // Reset in the middle of a frame.
        fork
            send_frame(8'h3A, 1'b0);
            begin
                repeat (150) @(posedge clk);
                reset_n = 1'b0;
                repeat (3) @(posedge clk);
                reset_n = 1'b1;
            end
        join
        model_clear();
        p0 = pulses;
        repeat (TIMEOUT + 500) @(posedge clk);
        chk("mid-frame reset pulses", 32'(pulses - p0), 32'd0);
        rows_chk(8'h00, 5'b11111, "mid-frame reset columns");
        chk("mid-frame reset scancode", 32'(scancode), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
